// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, runs one req/ack transaction at a time to
// instruction memory and queues fetched words for decode behind valid/ready.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state, state_nxt;
    logic [15:0]   fetch_pc, fetch_pc_nxt;
    logic [15:0]   drop_addr;
    logic [15:0]   buf_ir [DEPTH];
    logic [15:0]   buf_pc [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          push, pop, room;

    // A redirect flushes the buffer, so neither a pop nor a push takes effect.
    assign pop       = ir_valid && ir_ready && !redirect;
    assign push      = (state == WAIT) && imem_ack && !redirect;
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign room      = count_nxt < CW'(DEPTH);

    assign imem_req  = (state != IDLE);
    assign imem_addr = (state == DROP) ? drop_addr : fetch_pc;
    assign ir_valid  = (count != '0);
    assign ir        = buf_ir[rd_ptr];
    assign ir_pc     = buf_pc[rd_ptr];

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        if (redirect) begin
            fetch_pc_nxt = redirect_pc & 16'hFFFE;
            case (state)
                // Request still in flight: keep it up, throw its data away later.
                WAIT:    state_nxt = imem_ack ? WAIT : DROP;
                DROP:    state_nxt = DROP;
                default: state_nxt = WAIT;
            endcase
        end else begin
            case (state)
                IDLE: if (room) state_nxt = WAIT;
                WAIT: if (imem_ack) begin
                    fetch_pc_nxt = fetch_pc + 16'd2;
                    state_nxt    = room ? WAIT : IDLE;
                end
                DROP: if (imem_ack) state_nxt = WAIT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC & 16'hFFFE;
            drop_addr <= '0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_ir[i] <= '0;
                buf_pc[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (redirect && (state == WAIT) && !imem_ack)
                drop_addr <= fetch_pc;
            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count_nxt;
                if (push) begin
                    buf_ir[wr_ptr] <= imem_rdata;
                    buf_pc[wr_ptr] <= fetch_pc;
                    wr_ptr         <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, imem_req, imem_ack, redirect, ir_valid, ir_ready;
    logic [15:0] imem_addr, imem_rdata, redirect_pc, ir, ir_pc;

    logic        reset2, imem_req2, imem_ack2, ir_valid2, ir_ready2;
    logic [15:0] imem_addr2, imem_rdata2, ir2, ir_pc2;

    instr_fetch_unit #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) u_dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
        .ir_ready(ir_ready)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFC), .DEPTH(4)) u_dut2 (
        .clock(clock), .reset(reset2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .redirect(1'b0),
        .redirect_pc(16'h0000), .ir(ir2), .ir_pc(ir_pc2), .ir_valid(ir_valid2),
        .ir_ready(ir_ready2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=no request, 1=fetching m_fpc, 2=stale request at m_dpc.
    int          m_mode = 0;
    bit          m_ok   = 0;
    logic [15:0] m_fpc  = '0;
    logic [15:0] m_dpc  = '0;
    logic [31:0] m_q[$];

    always @(posedge clock) begin
        if (reset) begin
            m_ok   = 1;
            m_mode = 0;
            m_fpc  = 16'h0000;
            m_q.delete();
        end else if (m_ok) begin
            if (redirect) begin
                m_q.delete();
                if (m_mode == 1 && !imem_ack) begin
                    m_dpc  = m_fpc;
                    m_mode = 2;
                end else if (m_mode != 2) begin
                    m_mode = 1;
                end
                m_fpc = redirect_pc & 16'hFFFE;
            end else begin
                if (m_q.size() > 0 && ir_ready) void'(m_q.pop_front());
                case (m_mode)
                    0: if (m_q.size() < DEPTH) m_mode = 1;
                    1: if (imem_ack) begin
                        m_q.push_back({imem_rdata, m_fpc});
                        m_fpc  = m_fpc + 16'd2;
                        m_mode = (m_q.size() < DEPTH) ? 1 : 0;
                    end
                    default: if (imem_ack) m_mode = 1;
                endcase
            end
        end
    end

    always @(negedge clock) begin
        if (m_ok) begin
            chk("m_req", {31'd0, imem_req}, {31'd0, m_mode != 0});
            if (m_mode != 0)
                chk("m_addr", {16'd0, imem_addr}, {16'd0, (m_mode == 2) ? m_dpc : m_fpc});
            chk("m_valid", {31'd0, ir_valid}, {31'd0, m_q.size() != 0});
            if (m_q.size() != 0) begin
                chk("m_ir", {16'd0, ir}, {16'd0, m_q[0][31:16]});
                chk("m_ir_pc", {16'd0, ir_pc}, {16'd0, m_q[0][15:0]});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        imem_rdata = 16'($urandom);
    endtask

    initial begin
        reset = 1; imem_ack = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0; ir_ready = 0;
        reset2 = 1; imem_ack2 = 0; imem_rdata2 = 16'h1234; ir_ready2 = 0;
        step(); step();
        chk("rst_req", {31'd0, imem_req}, 0);
        chk("rst_valid", {31'd0, ir_valid}, 0);
        chk("rst_ir", {16'd0, ir}, 0);
        chk("rst_ir_pc", {16'd0, ir_pc}, 0);

        // Zero-wait memory, consumer always ready
        reset = 0; imem_ack = 1; ir_ready = 1;
        step(); chk("t1_req", {31'd0, imem_req}, 1); chk("t1_a0", {16'd0, imem_addr}, 16'h0000);
        chk("t1_v0", {31'd0, ir_valid}, 0);
        step(); chk("t1_a2", {16'd0, imem_addr}, 16'h0002); chk("t1_pc0", {16'd0, ir_pc}, 16'h0000);
        chk("t1_v1", {31'd0, ir_valid}, 1);
        step(); chk("t1_a4", {16'd0, imem_addr}, 16'h0004); chk("t1_pc2", {16'd0, ir_pc}, 16'h0002);

        // Backpressure fills the buffer, fetch stalls, then resumes without loss
        ir_ready = 0;
        step(); chk("t2_req0", {31'd0, imem_req}, 0); chk("t2_pc2", {16'd0, ir_pc}, 16'h0002);
        step(); chk("t2_req0b", {31'd0, imem_req}, 0); chk("t2_pc2b", {16'd0, ir_pc}, 16'h0002);
        ir_ready = 1;
        step(); chk("t2_a6", {16'd0, imem_addr}, 16'h0006); chk("t2_pc4", {16'd0, ir_pc}, 16'h0004);
        step(); chk("t2_a8", {16'd0, imem_addr}, 16'h0008); chk("t2_pc6", {16'd0, ir_pc}, 16'h0006);

        // Slow ack at address 4 with a redirect while it is outstanding
        reset = 1; step();
        reset = 0; imem_ack = 1; ir_ready = 1;
        step(); step(); step();
        imem_ack = 0;
        step(); chk("t3_hold", {16'd0, imem_addr}, 16'h0004);
        redirect = 1; redirect_pc = 16'h0040;
        step(); redirect = 0;
        chk("t3_req", {31'd0, imem_req}, 1); chk("t3_drop_a", {16'd0, imem_addr}, 16'h0004);
        chk("t3_flush", {31'd0, ir_valid}, 0);
        step(); chk("t3_drop_a2", {16'd0, imem_addr}, 16'h0004);
        imem_ack = 1;
        step(); chk("t3_new_a", {16'd0, imem_addr}, 16'h0040); chk("t3_v0", {31'd0, ir_valid}, 0);
        step(); chk("t3_v1", {31'd0, ir_valid}, 1); chk("t3_pc40", {16'd0, ir_pc}, 16'h0040);

        // Redirect coincident with ack, odd target
        redirect = 1; redirect_pc = 16'h0021;
        step(); redirect = 0;
        chk("t4_a20", {16'd0, imem_addr}, 16'h0020); chk("t4_v0", {31'd0, ir_valid}, 0);
        step(); chk("t4_v1", {31'd0, ir_valid}, 1); chk("t4_pc20", {16'd0, ir_pc}, 16'h0020);

        // Randomized traffic with varying memory latency
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                imem_ack    = ($urandom_range(0, 3) < (ph + 1));
                ir_ready    = ($urandom_range(0, 2) != 0);
                redirect    = ($urandom_range(0, 15) == 0);
                redirect_pc = 16'($urandom);
                reset       = ($urandom_range(0, 299) == 0);
                step();
            end
        end
        reset = 0; redirect = 0; imem_ack = 1; ir_ready = 1;

        // Address wrap from a high reset PC
        reset2 = 0; imem_ack2 = 1; ir_ready2 = 1;
        step(); chk("t5_fffc", {16'd0, imem_addr2}, 16'hFFFC);
        step(); chk("t5_fffe", {16'd0, imem_addr2}, 16'hFFFE);
        chk("t5_pc", {16'd0, ir_pc2}, 16'hFFFC); chk("t5_ir", {16'd0, ir2}, 16'h1234);
        step(); chk("t5_0000", {16'd0, imem_addr2}, 16'h0000);
        step(); chk("t5_0002", {16'd0, imem_addr2}, 16'h0002);

        // Reset while fetching with two entries buffered
        reset2 = 1; step();
        reset2 = 0; ir_ready2 = 0; imem_ack2 = 1;
        step(); step();
        chk("t6_pc", {16'd0, ir_pc2}, 16'hFFFC); chk("t6_v", {31'd0, ir_valid2}, 1);
        step(); chk("t6_req", {31'd0, imem_req2}, 1); chk("t6_a", {16'd0, imem_addr2}, 16'h0000);
        reset2 = 1;
        step(); chk("t6_rreq", {31'd0, imem_req2}, 0); chk("t6_rv", {31'd0, ir_valid2}, 0);
        reset2 = 0;
        step(); chk("t6_restart", {16'd0, imem_addr2}, 16'hFFFC); chk("t6_req1", {31'd0, imem_req2}, 1);
        chk("t6_v0", {31'd0, ir_valid2}, 0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
